// File: rtl/slow_clk_monitor.sv
// Measures period and high time of a slow asynchronous strobe in clk_in cycles; flags lock and stall.
// Latency: edge pulses and measurements appear 2-3 clk_in cycles after the asynchronous input edge.
// Backpressure: none; outputs are free-running strobes and held registers, no handshake.
module slow_clk_monitor #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_slow,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             stalled
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_V     = CNT_W'(TOL);
  localparam logic [MC_W-1:0]  LC_V      = MC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]  MC_ONE    = MC_W'(1);

  // s1/s2 form the synchronizer, s3 is one cycle of history for edge detection
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             have_prev;
  logic [MC_W-1:0]  match_cnt;

  logic             rise_evt;
  logic             fall_evt;
  logic             timeout_hit;
  logic [CNT_W-1:0] diff;
  logic             within_tol;
  logic [MC_W-1:0]  match_inc;

  assign rise_evt    = s2 & ~s3;
  assign fall_evt    = ~s2 & s3;
  assign timeout_hit = (cnt == TIMEOUT_V);
  // compare the running count against the previous period before it is overwritten
  assign diff        = (cnt >= period) ? (cnt - period) : (period - cnt);
  assign within_tol  = (diff <= TOL_V);
  assign match_inc   = (match_cnt == LC_V) ? match_cnt : (match_cnt + MC_ONE);

  // Synchronize the input, register edge pulses and run the saturating cycle counter
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      meas_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      s1         <= clk_slow;
      s2         <= s1;
      s3         <= s2;
      rise_pulse <= rise_evt;
      fall_pulse <= fall_evt;
      meas_valid <= rise_evt & armed;
      if (rise_evt) begin
        cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // Capture period/high time, track consecutive matching periods and detect stalls
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period    <= '0;
      high_time <= '0;
      locked    <= 1'b0;
      stalled   <= 1'b0;
      armed     <= 1'b0;
      have_prev <= 1'b0;
      match_cnt <= '0;
    end else if (rise_evt) begin
      // a rise always re-arms and clears a stall; only an armed rise yields a measurement
      armed   <= 1'b1;
      stalled <= 1'b0;
      if (armed) begin
        period <= cnt;
        if (!have_prev) begin
          have_prev <= 1'b1;
          match_cnt <= '0;
        end else if (within_tol) begin
          match_cnt <= match_inc;
          if (match_inc == LC_V) begin
            locked <= 1'b1;
          end
        end else begin
          match_cnt <= '0;
          locked    <= 1'b0;
        end
      end
    end else begin
      if (fall_evt && armed) begin
        high_time <= cnt;
      end
      // the rise branch above takes priority, so a period of exactly TIMEOUT still measures
      if (timeout_hit) begin
        stalled   <= 1'b1;
        armed     <= 1'b0;
        have_prev <= 1'b0;
        locked    <= 1'b0;
        match_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/slow_clk_monitor.md
# slow_clk_monitor

Measures a slow, asynchronous clock-like signal (typically a divided clock from a clock divider, or an external strobe) in units of the fast system clock `clk_in`. It synchronizes the input, emits single-cycle edge pulses, and reports period and high time. It also flags lock (stable period) and stall (no edges). It sits on the receiving side of the divided-clock path, so downstream logic uses clock enables instead of a derived clock.

## Interface
Parameters:
- `CNT_W`, default 16: width of the cycle counter and of the measurement outputs.
- `TIMEOUT`, default 1000: cycles without a rise event before `stalled` asserts. Constraint: 2 ≤ TIMEOUT ≤ 2^CNT_W − 2.
- `TOL`, default 1: maximum |period difference| for two measurements to count as matching.
- `LOCK_COUNT`, default 4: consecutive matches required to assert `locked` (≥ 1).

Ports:
- `clk_in`, input, 1: system clock, posedge.
- `rst`, input, 1: reset, asynchronous, active-high; clock clk_in.
- `clk_slow`, input, 1: monitored signal, asynchronous to `clk_in`.
- `rise_pulse`, output, 1: one-cycle pulse per synchronized rising edge.
- `fall_pulse`, output, 1: one-cycle pulse per synchronized falling edge.
- `period`, output, CNT_W: last measured rise-to-rise distance in `clk_in` cycles.
- `high_time`, output, CNT_W: last measured rise-to-fall distance in `clk_in` cycles.
- `meas_valid`, output, 1: one-cycle pulse when `period` is updated.
- `locked`, output, 1: period stable within TOL for LOCK_COUNT consecutive matches.
- `stalled`, output, 1: no rise event for TIMEOUT cycles.

## Operation
- Synchronizer and history: `s1 <= clk_slow`, `s2 <= s1`, `s3 <= s2`.
  - Rise event when `s2 & ~s3`.
  - Fall event when `~s2 & s3`.
  - The two events are mutually exclusive.
- Edge pulses: `rise_pulse` and `fall_pulse` are registered and set at the event edge for exactly one cycle.
- Counter `cnt`:
  - On a rise event, `cnt <= 1`.
  - Otherwise `cnt` increments, saturating at all-ones.
- `armed` flag:
  - Set by any rise event.
  - Cleared by reset and by stall.
- Rise event with `armed=1`:
  - `period <= cnt`.
  - `meas_valid` pulses.
  - Lock update runs.
- Rise event with `armed=0`: arms only; no `meas_valid`, `period` unchanged.
- Fall event with `armed=1`: `high_time <= cnt`. No valid strobe. A fall event with `armed=0` is ignored.
- Lock logic, using `have_prev` (a previous measurement exists since arming) and `match_cnt` (saturates at LOCK_COUNT):
  - First measurement after arming: no comparison; `match_cnt <= 0`; `have_prev <= 1`.
  - Later measurement with |cnt − period| ≤ TOL: `match_cnt++`. `locked <= 1` when the new `match_cnt` equals LOCK_COUNT.
  - Mismatch: `match_cnt <= 0`; `locked <= 0`.
- Stall:
  - Trigger: at an edge where the pre-edge `cnt` equals TIMEOUT and there is no rise event.
  - Action: `stalled <= 1`; `armed`, `have_prev`, `locked`, `match_cnt` all cleared.
  - A period of exactly TIMEOUT is therefore still measurable; TIMEOUT+1 is not.
  - `stalled` stays high until the next rise event, which clears it and re-arms without producing a measurement.
- Rise event and timeout at the same edge: the rise event wins and no stall occurs.

## Timing
- Reset values: all outputs 0; `s1..s3`, `cnt`, `armed`, `have_prev`, `match_cnt` all 0.
- Reset is immediate and mid-operation safe. The measurement in progress is discarded.
- If `clk_slow` is high when reset releases, a rise event follows. It only arms.
- Edge latency: with `clk_slow` low at posedge N−1 and high at posedge N (setup met):
  - `s1=1` after N, `s2=1` after N+1.
  - The rise event is evaluated at N+2, so `rise_pulse`, `meas_valid` and `period` are visible after posedge N+2.
  - Total latency is 2–3 `clk_in` cycles from the asynchronous edge.
- `period`, `high_time` and `locked` hold their values between updates.
- Minimum resolvable input: high and low phases of ≥ 2 `clk_in` cycles each, giving period ≥ 4. Shorter pulses may be missed. This is not an error condition.

## Test plan
- Reset check: assert `rst` asynchronously between clock edges -> all outputs 0 immediately and while held.
- Periodic input, high 2 / low 2 cycles, phase-aligned to `clk_in`, TOL=1, LOCK_COUNT=4 ->
  - 1st rise event arms only.
  - 2nd rise event: `meas_valid` with `period=4`; `high_time=2` after the first fall following an armed rise.
  - `locked=1` at the 6th rise event.
  - `rise_pulse` appears 2 cycles after `s1` rises.
- Period change 4 -> 10 (high 5) while locked ->
  - First 10-cycle measurement: `period=10`, `locked=0`.
  - `locked=1` again after 4 further matching 10-cycle periods.
- Jitter, periods 10, 9, 10, 9, 10, 9 -> `locked` asserts and holds. A following period of 12 (diff 3) -> `locked=0`.
- Stall with TIMEOUT=20 after lock; hold `clk_slow` constant ->
  - `stalled=1` exactly 20 cycles after the last rise event, `locked=0`.
  - Resume: 1st rise event clears `stalled`, no `meas_valid`; 2nd rise event gives a valid `period`.
  - Period exactly 20 measures as 20 with no stall.
- `rst` pulsed mid-period while locked -> outputs cleared. Post-reset, the first rise event only arms and the second gives the correct `period`.
